instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multi-cycle MIPS instruction fetch stage, directly upstream of the control unit.
//  Holds the PC and issues requests to instruction memory over a req/ack handshake.
//  Latches the returned word into an instruction register and drives Op/Funct to decode.
//  Computes the next PC from the Branch/Zero/Jump feedback of the current instruction.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be word-aligned
//  MAX_WAIT  16             max cycles in REQ without IMemAck before the fault state
//  CNT_W     32             width of the retired-instruction counter
// PORTS
//  CLK         in   1      clock, rising edge
//  RESET       in   1      asynchronous, active-low reset
//  Stall       in   1      hold the current instruction in EXEC
//  Branch      in   1      current instr is BEQ (from control unit)
//  Zero        in   1      ALU zero flag for the current instr
//  Jump        in   1      current instr is J (from control unit)
//  IMemAddr    out  32     fetch address (= PC)
//  IMemReq     out  1      fetch request
//  IMemRdata   in   32     instruction word; valid when IMemAck=1
//  IMemAck     in   1      memory response strobe
//  Instr       out  32     instruction register
//  InstrValid  out  1      Instr holds a valid word (state EXEC)
//  Op          out  6      Instr[31:26]
//  Funct       out  6      Instr[5:0]
//  PC          out  32     address of Instr
//  PCPlus4     out  32     PC + 4
//  InstrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
//  FetchErr    out  1      sticky fetch timeout flag
// BEHAVIOUR
//  Reset (RESET=0, async): PC=RESET_PC; Instr=0; InstrValid=0; IMemReq=0; InstrCount=0;
//   FetchErr=0; state=IDLE; wait counter=0. A reset in any state, including
//   mid-handshake, aborts the fetch and drops IMemReq immediately.
//  FSM states: IDLE, REQ, EXEC, FAULT.
//  IDLE: one cycle after reset release, then go to REQ.
//  REQ: IMemReq=1, IMemAddr=PC, wait counter increments each cycle.
//   On IMemAck=1 (zero-wait ack in the first REQ cycle is allowed):
//   Instr<=IMemRdata, go to EXEC, clear the counter.
//   If the counter reaches MAX_WAIT without an ack: go to FAULT, FetchErr<=1.
//  EXEC: InstrValid=1, IMemReq=0.
//   Stall=1: hold everything.
//   Stall=0: PC<=NextPC, InstrCount++, go to REQ.
//  FAULT: IMemReq=0, InstrValid=0. Exit only through reset.
//  IMemAck outside REQ is ignored, as is IMemRdata.
//  NextPC (combinational, 32-bit, wraps mod 2^32):
//   Jump=1      -> {PCPlus4[31:28], Instr[25:0], 2'b00}; Jump has priority over Branch.
//   Branch&Zero -> PCPlus4 + ({{14{Instr[15]}}, Instr[15:0], 2'b00}).
//   otherwise   -> PCPlus4.
//  Branch, Zero and Jump are sampled only in EXEC with Stall=0; they are don't-care elsewhere.
//  Latency: with zero-wait memory, one instruction per 2 cycles (REQ, EXEC).
//  Op, Funct, PC and PCPlus4 are stable for the whole EXEC period, including stalls.
// STRUCTURE
//  Shared include mips_defs.vh holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
//   OP_ADDI, OP_J) and the fetch FSM state encoding, so control and fetch agree.
//  Sub-module next_pc_logic (combinational): inputs PC, Instr, Branch, Zero, Jump;
//   outputs PCPlus4 and NextPC.
//  Top level contains the FSM, PC register, instruction register, wait counter and
//   InstrCount.
// TESTING
//  1. Reset release, ack in first REQ cycle with 0x8C08_0004 -> IMemAddr=0,
//     Instr=0x8C080004, Op=6'h23, InstrValid=1 in cycle 3.
//  2. EXEC PC=0x40, Instr=0x1000_FFFF, Branch=1, Zero=1 -> next IMemAddr=0x40;
//     same instr with Zero=0 -> 0x44.
//  3. PC=0x1000_0000, Instr=0x0800_0010, Jump=1, Branch=1, Zero=1 -> IMemAddr=0x1000_0040
//     (jump wins).
//  4. Stall=1 for 5 EXEC cycles -> PC, Instr and InstrCount unchanged;
//     one increment once Stall=0.
//  5. Ack withheld for MAX_WAIT cycles -> FetchErr=1, IMemReq=0, stays in FAULT;
//     a late ack is ignored.
//  6. RESET asserted mid-REQ at PC=0x80 -> IMemReq=0 asynchronously; after release
//     IMemAddr=RESET_PC and InstrCount=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared opcode constants and fetch FSM encoding, so the control unit and the
// fetch stage agree on instruction decoding and on the meaning of FsmState.
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Sequential-PC, BEQ-target and J-target selection for the fetch stage.
// Jump outranks a taken branch; all arithmetic wraps modulo 2^32.
module instr_fetch_unit_next_pc_logic (
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
    end else if (branch && zero) begin
      // The branch immediate is the low 16 bits of the instruction, in words.
      next_pc = pc_plus4 + {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle MIPS fetch stage: PC register, instruction register, fetch FSM,
// memory-timeout watchdog and retired-instruction counter.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             Jump,
  output logic [31:0]      IMemAddr,
  output logic             IMemReq,
  input  logic [31:0]      IMemRdata,
  input  logic             IMemAck,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  output logic [5:0]       Op,
  output logic [5:0]       Funct,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic [CNT_W-1:0] InstrCount,
  output logic             FetchErr,
  output fetch_state_e     FsmState
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  fetch_state_e      state;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic              req_q;
  logic              valid_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       pc_plus4;
  logic [31:0]       next_pc;

  instr_fetch_unit_next_pc_logic u_next_pc (
    .pc        (pc_q),
    .instr_idx (instr_q[25:0]),
    .branch    (Branch),
    .zero      (Zero),
    .jump      (Jump),
    .pc_plus4  (pc_plus4),
    .next_pc   (next_pc)
  );

  // Memory handshake: IMemReq is held high with a stable IMemAddr for every
  // REQ cycle; a cycle with IMemReq=1 and IMemAck=1 transfers IMemRdata and
  // ends the request. IMemAck while IMemReq=0 carries no meaning.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          if (IMemAck) begin
            instr_q <= IMemRdata;
            state   <= S_EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            wait_q  <= '0;
          end else if (wait_q == LAST_WAIT) begin
            // MAX_WAIT request cycles went unanswered; only reset recovers.
            state  <= S_FAULT;
            req_q  <= 1'b0;
            err_q  <= 1'b1;
            wait_q <= '0;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_EXEC: begin
          if (!Stall) begin
            pc_q    <= next_pc;
            cnt_q   <= cnt_q + CNT_W'(1);
            state   <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

  assign IMemAddr   = pc_q;
  assign IMemReq    = req_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign Op         = instr_q[31:26];
  assign Funct      = instr_q[5:0];
  assign PC         = pc_q;
  assign PCPlus4    = pc_plus4;
  assign InstrCount = cnt_q;
  assign FetchErr   = err_q;
  assign FsmState   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a hand-computed instruction program, random
// instructions against an arithmetic next-PC model, then reset and timeout cases.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          MAX_WAIT = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Stall = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] IMemRdata = '0;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemAddr;
  logic        IMemReq;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] InstrCount;
  logic        FetchErr;
  fetch_state_e FsmState;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT), .CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .Stall(Stall), .Branch(Branch), .Zero(Zero),
    .Jump(Jump), .IMemAddr(IMemAddr), .IMemReq(IMemReq), .IMemRdata(IMemRdata),
    .IMemAck(IMemAck), .Instr(Instr), .InstrValid(InstrValid), .Op(Op),
    .Funct(Funct), .PC(PC), .PCPlus4(PCPlus4), .InstrCount(InstrCount),
    .FetchErr(FetchErr), .FsmState(FsmState)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_cnt;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b0; Stall = 1'b0; IMemAck = 1'b0;
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    #2;
    chk("rst_req", 32'(IMemReq), 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_err", 32'(FetchErr), 32'd0);
    chk("rst_state", 32'(FsmState), 32'(S_IDLE));
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rel_addr", IMemAddr, RESET_PC);
    chk("rel_count", InstrCount, 32'd0);
    chk("rel_req", 32'(IMemReq), 32'd0);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    m_cnt = '0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit b, input bit z, input bit j);
    int off;
    if (j) return ((pc + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = $signed(w[15:0]);
      return pc + 32'd4 + 32'(off * 4);
    end
    return pc + 32'd4;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (IMemReq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: got IMemReq=%b expected 1 within 40 cycles", IMemReq);
    end
  endtask

  task automatic check_next_fetch();
    bit ok;
    logic [31:0] a;
    wait_req(ok);
    if (!ok) return;
    a = exp_q.pop_front();
    chk("fetch_addr", IMemAddr, a);
  endtask

  task automatic fetch_exec(input logic [31:0] w, input int lat, input int stalls,
                            input bit b, input bit z, input bit j);
    bit ok;
    logic [31:0] a;
    wait_req(ok);
    if (!ok) return;
    a = exp_q.pop_front();
    chk("fetch_addr", IMemAddr, a);
    for (int i = 0; i < lat; i++) begin
      Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
      IMemRdata = $urandom();
      step();
      chk("wait_req", 32'(IMemReq), 32'd1);
    end
    IMemAck = 1'b1; IMemRdata = w;
    step();
    IMemAck = 1'b0; IMemRdata = $urandom();
    chk("valid", 32'(InstrValid), 32'd1);
    chk("instr", Instr, w);
    chk("op", 32'(Op), 32'(w[31:26]));
    chk("funct", 32'(Funct), 32'(w[5:0]));
    chk("pc", PC, a);
    chk("pc_plus4", PCPlus4, a + 32'd4);
    chk("req_low", 32'(IMemReq), 32'd0);
    for (int i = 0; i < stalls; i++) begin
      Stall = 1'b1;
      Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
      IMemAck = 1'($urandom); IMemRdata = $urandom();
      step();
      chk("stall_pc", PC, a);
      chk("stall_instr", Instr, w);
      chk("stall_count", InstrCount, m_cnt);
      chk("stall_valid", 32'(InstrValid), 32'd1);
    end
    Stall = 1'b0; IMemAck = 1'b0;
    Branch = b; Zero = z; Jump = j;
    step();
    m_cnt = m_cnt + 32'd1;
    chk("count", InstrCount, m_cnt);
    chk("req_again", 32'(IMemReq), 32'd1);
    Branch = 1'($urandom); Zero = 1'($urandom); Jump = 1'($urandom);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] word;
    int          lat;
    int          stalls;
    bit          b;
    bit          z;
    bit          j;
    logic [31:0] next;
  } vec_t;

  vec_t tbl[12];

  initial begin
    bit ok;
    logic [31:0] w;
    logic [31:0] nx;
    bit b, z, j;

    tbl[0]  = '{32'h8C08_0004, 0,  0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
    tbl[1]  = '{32'h0800_0010, 1,  0, 1'b0, 1'b0, 1'b1, 32'h0000_0040};
    tbl[2]  = '{32'h1000_FFFF, 0,  1, 1'b1, 1'b1, 1'b0, 32'h0000_0040};
    tbl[3]  = '{32'h1000_FFFF, 2,  0, 1'b1, 1'b0, 1'b0, 32'h0000_0044};
    tbl[4]  = '{32'h1000_0003, 0,  5, 1'b1, 1'b1, 1'b0, 32'h0000_0054};
    tbl[5]  = '{32'h0800_0020, 3,  0, 1'b1, 1'b1, 1'b1, 32'h0000_0080};
    tbl[6]  = '{32'h0000_0020, 15, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0084};
    tbl[7]  = '{32'h0BFF_FFFF, 0,  2, 1'b0, 1'b0, 1'b1, 32'h0FFF_FFFC};
    tbl[8]  = '{32'h0000_0000, 1,  0, 1'b0, 1'b0, 1'b0, 32'h1000_0000};
    tbl[9]  = '{32'h0800_0010, 0,  0, 1'b1, 1'b1, 1'b1, 32'h1000_0040};
    tbl[10] = '{32'h1000_8000, 0,  1, 1'b1, 1'b1, 1'b0, 32'h0FFE_0044};
    tbl[11] = '{32'h2008_0001, 4,  0, 1'b0, 1'b1, 1'b0, 32'h0FFE_0048};

    // Reset, then the first REQ cycle directly follows the single IDLE cycle.
    apply_reset();
    step();
    chk("first_req", 32'(IMemReq), 32'd1);
    chk("first_state", 32'(FsmState), 32'(S_REQ));

    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].next);
      fetch_exec(tbl[i].word, tbl[i].lat, tbl[i].stalls, tbl[i].b, tbl[i].z, tbl[i].j);
      if (i == 0) chk("op_lw", 32'(Op), 32'(OP_LW));
    end

    // Random instructions scored against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: w = {OP_J, 26'($urandom)};
        1: w = {OP_BEQ, 10'($urandom), 16'($urandom)};
        default: w = $urandom();
      endcase
      b = 1'($urandom); z = 1'($urandom); j = 1'($urandom);
      nx = model_next(exp_q[$], w, b, z, j);
      exp_q.push_back(nx);
      fetch_exec(w, $urandom_range(0, 3), $urandom_range(0, 2), b, z, j);
    end
    check_next_fetch();

    // Reset asserted mid-request at PC 0x80 drops IMemReq without a clock edge.
    apply_reset();
    exp_q.push_back(32'h0000_0080);
    fetch_exec(32'h0800_0020, 1, 0, 1'b0, 1'b0, 1'b1);
    check_next_fetch();
    #3;
    RESET = 1'b0;
    #1;
    chk("async_req_drop", 32'(IMemReq), 32'd0);
    apply_reset();

    // Unanswered request: fault after exactly MAX_WAIT cycles, then sticky.
    wait_req(ok);
    if (ok) begin
      chk("to_addr", IMemAddr, RESET_PC);
      for (int i = 0; i < MAX_WAIT - 1; i++) step();
      chk("to_not_yet_err", 32'(FetchErr), 32'd0);
      chk("to_not_yet_req", 32'(IMemReq), 32'd1);
      step();
      chk("to_err", 32'(FetchErr), 32'd1);
      chk("to_req", 32'(IMemReq), 32'd0);
      chk("to_valid", 32'(InstrValid), 32'd0);
      chk("to_state", 32'(FsmState), 32'(S_FAULT));
      IMemAck = 1'b1; IMemRdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) step();
      IMemAck = 1'b0;
      chk("late_ack_err", 32'(FetchErr), 32'd1);
      chk("late_ack_req", 32'(IMemReq), 32'd0);
      chk("late_ack_valid", 32'(InstrValid), 32'd0);
      chk("late_ack_instr", Instr, 32'd0);
      chk("late_ack_state", 32'(FsmState), 32'(S_FAULT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
